// File: rtl/fp_mul_pkg.sv
// Shared constants, operand class enum and format helpers for the FP multiplier.
// Ports: none (package).
package fp_mul_pkg;

   // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
   localparam int unsigned FLAG_W         = 4;
   localparam int unsigned FLAG_INVALID   = 3;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_INEXACT   = 0;

   // Working width of the helper results; callers cast down to the word width
   localparam int unsigned HELPER_W = 64;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_e;

   // Exponent bias for an exp_w-bit exponent field
   function automatic logic [HELPER_W-1:0] fp_bias(input int unsigned exp_w);
      return (HELPER_W'(1) << (exp_w - 1)) - HELPER_W'(1);
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
   function automatic logic [HELPER_W-1:0] fp_canon_nan(input int unsigned exp_w,
                                                         input int unsigned man_w);
      logic [HELPER_W-1:0] e_ones;
      e_ones = (HELPER_W'(1) << exp_w) - HELPER_W'(1);
      return (e_ones << man_w) | (HELPER_W'(1) << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Final-stage combinational logic: normalise the mantissa product, round,
// apply exception overrides and pack the result word with its flags.
// Build option: FP_MUL_PIPE_ROUND_EN selects round-to-nearest-even,
// otherwise the fraction is truncated (inexact is reported either way).
// Ports:
//   sign_i    - result sign
//   exp_i     - biased exponent sum (signed, EXP_W+2 bits)
//   prod_i    - (MAN_W+1)x(MAN_W+1) significand product
//   cls_i     - result class decided from the operand classes
//   res_c_o   - packed result word
//   flags_c_o - {invalid, overflow, underflow, inexact}
module fp_mul_norm_round
   import fp_mul_pkg::*;
#(
   parameter  int unsigned EXP_W  = 8,
   parameter  int unsigned MAN_W  = 23,
   localparam int unsigned W      = 1 + EXP_W + MAN_W,
   localparam int unsigned E2_W   = EXP_W + 2,
   localparam int unsigned PROD_W = 2 * (MAN_W + 1)
)(
   input  logic                    sign_i,
   input  logic signed [E2_W-1:0]  exp_i,
   input  logic [PROD_W-1:0]       prod_i,
   input  fp_class_e               cls_i,
   output logic [W-1:0]            res_c_o,
   output logic [FLAG_W-1:0]       flags_c_o
);

   localparam logic signed [E2_W-1:0] EXP_MAX  = E2_W'((2 ** EXP_W) - 1);
   localparam logic signed [E2_W-1:0] EXP_ZERO = '0;

   logic [PROD_W-2:0]       low;
   logic [MAN_W-1:0]        frac;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;
   logic [MAN_W:0]          frac_r;
   logic signed [E2_W-1:0]  exp_n;
   logic signed [E2_W-1:0]  exp_f;

   // Normalise, round, then resolve overflow/underflow and special classes
   always_comb begin
      // Product is in [1,4): drop the leading one, shifting left when it sits one bit lower
      low    = prod_i[PROD_W-1] ? prod_i[PROD_W-2:0] : {prod_i[PROD_W-3:0], 1'b0};
      exp_n  = exp_i + signed'(E2_W'(prod_i[PROD_W-1]));
      frac   = low[PROD_W-2 -: MAN_W];
      guard  = low[MAN_W];
      sticky = |low[MAN_W-1:0];
`ifdef FP_MUL_PIPE_ROUND_EN
      round_up = guard & (sticky | frac[0]);
`else
      round_up = 1'b0;
`endif
      // A carry out of the fraction leaves it zero and bumps the exponent
      frac_r = {1'b0, frac} + (MAN_W+1)'(round_up);
      exp_f  = exp_n + signed'(E2_W'(frac_r[MAN_W]));

      res_c_o                 = {sign_i, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
      flags_c_o               = '0;
      flags_c_o[FLAG_INEXACT] = guard | sticky;

      if (exp_f >= EXP_MAX) begin
         res_c_o                   = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_c_o[FLAG_OVERFLOW]  = 1'b1;
         flags_c_o[FLAG_INEXACT]   = 1'b1;
      end else if (exp_f <= EXP_ZERO) begin
         res_c_o                   = {sign_i, {(W-1){1'b0}}};
         flags_c_o[FLAG_UNDERFLOW] = 1'b1;
         flags_c_o[FLAG_INEXACT]   = 1'b1;
      end

      unique case (cls_i)
         CLS_NAN: begin
            res_c_o                 = W'(fp_canon_nan(EXP_W, MAN_W));
            flags_c_o               = '0;
            flags_c_o[FLAG_INVALID] = 1'b1;
         end
         CLS_INF: begin
            res_c_o   = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c_o = '0;
         end
         CLS_ZERO: begin
            res_c_o   = {sign_i, {(W-1){1'b0}}};
            flags_c_o = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// S1 unpacks and classifies, S2 multiplies significands, S3 normalises,
// rounds and packs into the output register. A single global stall freezes
// every stage while the output is valid and not accepted.
// Build option: FP_MUL_PIPE_ROUND_EN (round-to-nearest-even; default truncate).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake for a, b
//   a, b                  - operands {sign, exp, frac}
//   out_valid / out_ready - result handshake for mul, flags
//   mul                   - product
//   flags                 - {invalid, overflow, underflow, inexact}
module fp_mul_pipe
   import fp_mul_pkg::*;
#(
   parameter  int unsigned EXP_W = 8,
   parameter  int unsigned MAN_W = 23,
   localparam int unsigned W     = 1 + EXP_W + MAN_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      mul,
   output logic [FLAG_W-1:0] flags
);

   localparam int unsigned E2_W   = EXP_W + 2;
   localparam int unsigned SIG_W  = MAN_W + 1;
   localparam int unsigned PROD_W = 2 * SIG_W;
   localparam logic signed [E2_W-1:0] BIAS = signed'(E2_W'(fp_bias(EXP_W)));

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] f);
      fp_class_e c;
      c = CLS_NORM;
      if (e == '0)      c = CLS_ZERO;
      else if (e == '1) c = (f == '0) ? CLS_INF : CLS_NAN;
      return c;
   endfunction

   // Stage registers
   logic                   s1_valid_q, s2_valid_q, out_valid_q;
   logic                   s1_sign_q, s2_sign_q;
   logic signed [E2_W-1:0] s1_exp_q, s2_exp_q;
   logic [SIG_W-1:0]       s1_siga_q, s1_sigb_q;
   fp_class_e              s1_cls_q, s2_cls_q;
   logic [PROD_W-1:0]      s2_prod_q;
   logic [W-1:0]           mul_q;
   logic [FLAG_W-1:0]      flags_q;

   // Next-state values
   logic                   s1_sign_d;
   logic signed [E2_W-1:0] s1_exp_d;
   logic [SIG_W-1:0]       s1_siga_d, s1_sigb_d;
   fp_class_e              s1_cls_d;
   logic [PROD_W-1:0]      s2_prod_d;
   fp_class_e              cls_a, cls_b;
   logic [W-1:0]           res_c;
   logic [FLAG_W-1:0]      flags_c;

   // Global stall: everything advances only when the output slot can move
   assign in_ready = !(out_valid_q && !out_ready);

   // S1: unpack, sign, biased exponent sum and result class
   always_comb begin
      cls_a     = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
      cls_b     = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
      s1_sign_d = a[W-1] ^ b[W-1];
      s1_exp_d  = signed'(E2_W'(a[W-2 -: EXP_W])) + signed'(E2_W'(b[W-2 -: EXP_W])) - BIAS;
      s1_siga_d = {1'b1, a[MAN_W-1:0]};
      s1_sigb_d = {1'b1, b[MAN_W-1:0]};
      s1_cls_d  = CLS_NORM;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
          (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
          (cls_a == CLS_ZERO && cls_b == CLS_INF))
         s1_cls_d = CLS_NAN;
      else if (cls_a == CLS_INF || cls_b == CLS_INF)
         s1_cls_d = CLS_INF;
      else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
         s1_cls_d = CLS_ZERO;
   end

   // S2: significand product
   assign s2_prod_d = PROD_W'(s1_siga_q) * PROD_W'(s1_sigb_q);

   // S3: normalise / round / pack
   fp_mul_norm_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_norm_round (
      .sign_i    (s2_sign_q),
      .exp_i     (s2_exp_q),
      .prod_i    (s2_prod_q),
      .cls_i     (s2_cls_q),
      .res_c_o   (res_c),
      .flags_c_o (flags_c)
   );

   // Pipeline registers; reset drops every in-flight slot
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_exp_q    <= '0;
         s1_siga_q   <= '0;
         s1_sigb_q   <= '0;
         s1_cls_q    <= CLS_ZERO;
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_exp_q    <= '0;
         s2_prod_q   <= '0;
         s2_cls_q    <= CLS_ZERO;
         out_valid_q <= 1'b0;
         mul_q       <= '0;
         flags_q     <= '0;
      end else if (in_ready) begin
         s1_valid_q  <= in_valid;
         s1_sign_q   <= s1_sign_d;
         s1_exp_q    <= s1_exp_d;
         s1_siga_q   <= s1_siga_d;
         s1_sigb_q   <= s1_sigb_d;
         s1_cls_q    <= s1_cls_d;
         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_exp_q    <= s1_exp_q;
         s2_prod_q   <= s2_prod_d;
         s2_cls_q    <= s1_cls_q;
         out_valid_q <= s2_valid_q;
         // Bubbles leave the last result on the bus untouched
         if (s2_valid_q) begin
            mul_q   <= res_c;
            flags_q <= flags_c;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign mul       = mul_q;
   assign flags     = flags_q;

endmodule
